move_collector: RTL

- Downstream of the 2x2 square array. Consumes the per-square directional move buses (12 x 32-bit).
- After a board evaluation, it waits for the square network to settle, then snapshots all buses.
- It scans the snapshot one source per cycle and queues every valid move word into a FIFO.
- The engine drains the FIFO through a valid/ready handshake.

---
 rtl/move_collector.sv | 137 +++++++++++++
 1 files changed

// File: rtl/move_collector.sv
// Snapshots the square-array move buses after a settle delay, scans them one
// source per cycle and queues every valid move word into a fall-through FIFO.
module move_collector #(
  parameter int unsigned NUM_SRC       = 12,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  flush,
  input  logic [NUM_SRC*32-1:0] move_bus,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_move,
  output logic [3:0]            out_src,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            move_count
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   settle_cnt;
  logic [3:0]      idx;
  logic [31:0]     snapshot [NUM_SRC];

  logic [31:0]     fifo_move [FIFO_DEPTH];
  logic [3:0]      fifo_src  [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     fifo_cnt;

  logic            fifo_full;
  logic            fifo_empty;
  logic [31:0]     cur_word;
  logic            push;
  logic            pop;
  logic            last_idx;

  // Full is taken from the registered count, so a same-cycle pop never frees room for a push.
  always_comb begin
    fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
    fifo_empty = (fifo_cnt == '0);
    cur_word   = snapshot[idx];
    last_idx   = (idx == 4'(NUM_SRC - 1));
    push       = (state == S_SCAN) && !flush && cur_word[31] && !fifo_full;
    pop        = !fifo_empty && out_ready && !flush;
  end

  always_comb begin
    out_valid = !fifo_empty;
    out_move  = fifo_empty ? '0 : fifo_move[rd_ptr];
    out_src   = fifo_empty ? '0 : fifo_src[rd_ptr];
    busy      = (state == S_SETTLE) || (state == S_SCAN) || (state == S_DRAIN);
    done      = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      idx        <= '0;
      move_count <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) snapshot[i] <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_SETTLE;
            settle_cnt <= CW'(SETTLE_CYCLES - 1);
            move_count <= '0;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) snapshot[i] <= move_bus[32*i +: 32];
            idx   <= '0;
            state <= S_SCAN;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        S_SCAN: begin
          // A valid word with the FIFO full holds idx so the move is retried, never dropped.
          if (!cur_word[31] || !fifo_full) begin
            idx <= idx + 1'b1;
            if (last_idx) state <= S_DRAIN;
          end
          if (push && (move_count != 8'hFF)) move_count <= move_count + 1'b1;
        end
        S_DRAIN: begin
          if (fifo_empty) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_move[wr_ptr] <= cur_word;
      fifo_src[wr_ptr]  <= idx;
    end
  end

endmodule
